tlc_lamp_driver: RTL and testbench

- Downstream stage of the traffic-light controller `tlc`; consumes its `state[1:0]` and `count[3:0]` outputs.
- Drives the physical lamp outputs for both roads and the pedestrian crossing, including flashing "don't walk" near the end of a phase.
- Independently checks that `tlc` follows the legal phase sequence and is not stuck; on any violation, latches a fault and forces flashing-amber safe mode until reset.

---
 rtl/tlc_pkg.sv | 27 ++
 rtl/tlc_lamp_driver_if.sv | 33 +++
 rtl/tlc_lamp_driver_blink_gen.sv | 37 +++
 rtl/tlc_lamp_driver.sv | 122 ++++++++++++
 tb/tb_tlc_lamp_driver.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/tlc_pkg.sv
// Shared phase encoding and lamp constants for the traffic-light controller
// and its downstream lamp driver.
package tlc_pkg;

    typedef logic [1:0] phase_t;
    typedef logic [2:0] lamp_t;

    localparam phase_t S_NS_GREEN = 2'b00;
    localparam phase_t S_NS_AMBER = 2'b01;
    localparam phase_t S_EW_GREEN = 2'b10;
    localparam phase_t S_EW_AMBER = 2'b11;

    localparam int LAMP_RED = 2;
    localparam int LAMP_AMB = 1;
    localparam int LAMP_GRN = 0;

    localparam lamp_t LAMP_OFF = 3'b000;
    localparam lamp_t RED      = lamp_t'(1 << LAMP_RED);
    localparam lamp_t AMBER    = lamp_t'(1 << LAMP_AMB);
    localparam lamp_t GREEN    = lamp_t'(1 << LAMP_GRN);

    // The only legal successor of a phase; the sequence wraps EW_AMBER -> NS_GREEN.
    function automatic phase_t phase_succ(input phase_t p);
        return p + 2'd1;
    endfunction

endpackage

// File: rtl/tlc_lamp_driver_if.sv
// Phase inputs from the controller and lamp outputs toward the field hardware.
interface tlc_lamp_driver_if;
    import tlc_pkg::*;

    phase_t     state;
    logic [3:0] count;
    lamp_t      ns_lamp;
    lamp_t      ew_lamp;
    logic       ped_walk;
    logic       ped_dont;
    logic       fault;

    modport master (
        output state,
        output count,
        input  ns_lamp,
        input  ew_lamp,
        input  ped_walk,
        input  ped_dont,
        input  fault
    );

    modport slave (
        input  state,
        input  count,
        output ns_lamp,
        output ew_lamp,
        output ped_walk,
        output ped_dont,
        output fault
    );

endinterface

// File: rtl/tlc_lamp_driver_blink_gen.sv
// Free-running square wave: blink toggles every HALF clock cycles.
module blink_gen #(
    parameter int HALF = 4
) (
    input  logic clk,
    input  logic rst,
    output logic blink
);

    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          blink_q, blink_d;

    always_comb begin
        cnt_d   = cnt_q + CW'(1);
        blink_d = blink_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            blink_d = ~blink_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            blink_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
        end
    end

    assign blink = blink_q;

endmodule

// File: rtl/tlc_lamp_driver.sv
// Lamp decode for both roads and the crossing, plus an independent watchdog that
// latches a fault on illegal or stuck phases and falls back to flashing amber.
module tlc_lamp_driver
    import tlc_pkg::*;
#(
    parameter int BLINK_HALF = 4,
    parameter int MAX_DWELL  = 32,
    parameter int FLASH_TH   = 3
) (
    input  logic              clk,
    input  logic              rst,
    tlc_lamp_driver_if.slave  bus
);

    localparam int DW = $clog2(MAX_DWELL + 1);
    localparam logic [DW-1:0] DWELL_MAX = DW'(MAX_DWELL);
    localparam logic [3:0]    FLASH_LIM = 4'(FLASH_TH);

    logic blink;

    blink_gen #(
        .HALF (BLINK_HALF)
    ) u_blink (
        .clk   (clk),
        .rst   (rst),
        .blink (blink)
    );

    logic          armed_q, armed_d;
    phase_t        prev_q, prev_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          fault_q, fault_d;
    lamp_t         ns_q, ns_d;
    lamp_t         ew_q, ew_d;
    logic          walk_q, walk_d;
    logic          dont_q, dont_d;

    // Sequence watchdog. Once a fault is latched the checker freezes; the very
    // first sample after reset only seeds prev_state.
    always_comb begin
        armed_d = armed_q;
        prev_d  = prev_q;
        dwell_d = dwell_q;
        fault_d = fault_q;
        if (!armed_q) begin
            armed_d = 1'b1;
            prev_d  = bus.state;
            dwell_d = '0;
        end else if (!fault_q) begin
            prev_d = bus.state;
            if (bus.state == prev_q) begin
                if (dwell_q != DWELL_MAX) begin
                    dwell_d = dwell_q + DW'(1);
                end
                if (dwell_d == DWELL_MAX) begin
                    fault_d = 1'b1;
                end
            end else if (bus.state == phase_succ(prev_q)) begin
                dwell_d = '0;
            end else begin
                fault_d = 1'b1;
            end
        end
    end

    // Lamp decode uses the next fault value so safe mode appears together with fault.
    always_comb begin
        ns_d   = RED;
        ew_d   = RED;
        walk_d = 1'b0;
        dont_d = 1'b1;
        if (fault_d) begin
            ns_d = blink ? AMBER : LAMP_OFF;
            ew_d = blink ? AMBER : LAMP_OFF;
        end else begin
            unique case (bus.state)
                S_NS_GREEN: ns_d = GREEN;
                S_NS_AMBER: ns_d = AMBER;
                S_EW_GREEN: begin
                    ew_d = GREEN;
                    if (bus.count > FLASH_LIM) begin
                        walk_d = 1'b1;
                        dont_d = 1'b0;
                    end else begin
                        dont_d = blink;
                    end
                end
                S_EW_AMBER: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q <= 1'b0;
            prev_q  <= S_NS_GREEN;
            dwell_q <= '0;
            fault_q <= 1'b0;
            ns_q    <= RED;
            ew_q    <= RED;
            walk_q  <= 1'b0;
            dont_q  <= 1'b1;
        end else begin
            armed_q <= armed_d;
            prev_q  <= prev_d;
            dwell_q <= dwell_d;
            fault_q <= fault_d;
            ns_q    <= ns_d;
            ew_q    <= ew_d;
            walk_q  <= walk_d;
            dont_q  <= dont_d;
        end
    end

    assign bus.ns_lamp  = ns_q;
    assign bus.ew_lamp  = ew_q;
    assign bus.ped_walk = walk_q;
    assign bus.ped_dont = dont_q;
    assign bus.fault    = fault_q;

endmodule

// File: tb/tb_tlc_lamp_driver.sv
// Directed bench for tlc_lamp_driver with a reference model feeding a scoreboard.
module tb_tlc_lamp_driver;

    localparam int BLINK_HALF = 4;
    localparam int MAX_DWELL  = 32;
    localparam int FLASH_TH   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    tlc_lamp_driver_if bus();

    tlc_lamp_driver #(
        .BLINK_HALF (BLINK_HALF),
        .MAX_DWELL  (MAX_DWELL),
        .FLASH_TH   (FLASH_TH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Packed observation: {ns[2:0], ew[2:0], ped_walk, ped_dont, fault}
    logic [8:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;
    int step_no = 0;

    // Reference model state (run-length based watchdog, cycle-count based blink)
    int         m_cycles;
    bit         m_armed;
    bit         m_fault;
    logic [1:0] m_prev;
    int         m_run;

    task automatic model(input logic r, input logic [1:0] s, input logic [3:0] c,
                         output logic [8:0] e);
        logic       b;
        logic [1:0] succ;
        logic [2:0] ns, ew;
        logic       walk, dont;
        if (r) begin
            m_cycles = 0;
            m_armed  = 0;
            m_fault  = 0;
            m_run    = 0;
            e = {3'b100, 3'b100, 1'b0, 1'b1, 1'b0};
            return;
        end
        b = ((m_cycles / BLINK_HALF) % 2) == 1;
        m_cycles++;
        succ = m_prev + 2'd1;
        if (!m_fault) begin
            if (!m_armed) begin
                m_armed = 1;
                m_run   = 1;
            end else if (s == m_prev) begin
                m_run++;
                if (m_run > MAX_DWELL) m_fault = 1;
            end else if (s == succ) begin
                m_run = 1;
            end else begin
                m_fault = 1;
            end
            m_prev = s;
        end
        ns = 3'b100; ew = 3'b100; walk = 0; dont = 1;
        if (m_fault) begin
            ns = b ? 3'b010 : 3'b000;
            ew = ns;
        end else begin
            case (s)
                2'b00: ns = 3'b001;
                2'b01: ns = 3'b010;
                2'b10: begin
                    ew = 3'b001;
                    if (int'(c) > FLASH_TH) begin walk = 1; dont = 0; end
                    else dont = b;
                end
                default: ;
            endcase
        end
        e = {ns, ew, walk, dont, m_fault};
    endtask

    task automatic step(input logic r, input logic [1:0] s, input logic [3:0] c,
                        input string tag);
        logic [8:0] e, got;
        rst       = r;
        bus.state = s;
        bus.count = c;
        model(r, s, c, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = {bus.ns_lamp, bus.ew_lamp, bus.ped_walk, bus.ped_dont, bus.fault};
        e = exp_q.pop_front();
        vectors++;
        step_no++;
        $display("step %0d %s rst=%0b st=%0d cnt=%0d out=%b exp=%b",
                 step_no, tag, r, s, c, got, e);
        assert (got === e) else begin
            miscompares++;
            $error("FAIL %s step %0d: observed %b expected %b", tag, step_no, got, e);
        end
    endtask

    initial begin
        bus.state = 2'b00;
        bus.count = 4'd0;
        m_prev    = 2'b00;

        // Reset held for two cycles
        step(1, 2'b00, 4'd0, "reset");
        step(1, 2'b00, 4'd0, "reset");

        // Legal cycle, each phase held 5 samples with count 4..0
        for (int p = 0; p < 5; p++)
            for (int c = 4; c >= 0; c--)
                step(0, 2'(p % 4), 4'(c), "legal");

        // Walk into EW_GREEN and sweep the pedestrian countdown
        step(0, 2'b01, 4'd1, "ped_pre");
        step(0, 2'b01, 4'd0, "ped_pre");
        for (int c = 9; c >= 0; c--)
            step(0, 2'b10, 4'(c), "ped");
        for (int i = 0; i < 3; i++) step(0, 2'b11, 4'd0, "ped_post");
        for (int i = 0; i < 3; i++) step(0, 2'b00, 4'd5, "ped_post");

        // Illegal skip 00 -> 10, then a legal sequence must not clear the fault
        for (int i = 0; i < 6; i++) step(0, 2'b10, 4'd9, "skip");
        for (int p = 3; p < 8; p++)
            for (int i = 0; i < 3; i++)
                step(0, 2'(p % 4), 4'd7, "post_fault");

        // Reset during fault; first sample afterwards is not checked against prior state
        step(1, 2'b10, 4'd0, "rst_mid");
        step(0, 2'b11, 4'd0, "post_rst");
        for (int i = 0; i < 3; i++) step(0, 2'b00, 4'd2, "post_rst");

        // Stuck: 33 identical samples of 01 raise fault
        step(1, 2'b00, 4'd0, "stuck_rst");
        step(0, 2'b00, 4'd0, "stuck");
        for (int i = 0; i < MAX_DWELL + 1; i++) step(0, 2'b01, 4'd0, "stuck");
        for (int i = 0; i < 3; i++) step(0, 2'b01, 4'd0, "stuck_after");

        // 32 identical samples then a legal move: no fault
        step(1, 2'b00, 4'd0, "nostuck_rst");
        step(0, 2'b00, 4'd0, "nostuck");
        for (int i = 0; i < MAX_DWELL; i++) step(0, 2'b01, 4'd0, "nostuck");
        for (int i = 0; i < 3; i++) step(0, 2'b10, 4'd8, "nostuck_after");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
